imem_debug_loader: RTL and testbench

//   Programs the instruction cache through its debug port (write_en / debug_addr /

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_rotxor_checksum.sv | 35 +++
 rtl/imem_debug_loader.sv | 205 ++++++++++++++++++++
 tb/tb_imem_debug_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory debug loader.
// The shared checksum step is rotate-left-by-one, then XOR in the next word.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WDRAIN = 3'd2,
    VERIFY = 3'd3,
    RDRAIN = 3'd4,
    DONE   = 3'd5
  } state_e;

  function automatic logic [31:0] rotl1_xor(input logic [31:0] sum,
                                            input logic [31:0] word);
    rotl1_xor = {sum[30:0], sum[31]} ^ word;
  endfunction

endpackage

// File: rtl/imem_rotxor_checksum.sv
// Running rotate-xor checksum register. clear_i wins over en_i and returns
// the sum to zero for the next load.
module imem_rotxor_checksum
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [31:0] word_i,
  output logic [31:0] sum_o
);

  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (en_i) begin
      sum_d = rotl1_xor(sum_q, word_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/imem_debug_loader.sv
// Streams an image into the instruction cache debug port while holding the CPU.
// Define IMEM_LOADER_READBACK_EN to read the image back and compare checksums.
module imem_debug_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter logic [29:0] BASE_WORD = 30'd0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ADDR_W:0] word_count,
  input  logic            in_valid,
  input  logic [31:0]     in_data,
  output logic            in_ready,
  output logic            dbg_write_en,
  output logic [29:0]     dbg_addr,
  output logic [31:0]     dbg_wdata,
  input  logic [31:0]     dbg_rdata,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};

  state_e          state_q, state_d;
  logic [ADDR_W:0] n_q, n_d;
  logic [ADDR_W:0] idx_q, idx_d;
  logic            wr_en_q, wr_en_d;
  logic [29:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            handshake;
  logic            sum_clear;
  logic            wr_sum_en;
  logic [31:0]     wr_sum;

  // Stream handshake: a word transfers on a rising clk edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.
  assign in_ready  = (state_q == LOAD);
  assign handshake = in_valid & in_ready;

  imem_rotxor_checksum u_wr_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (sum_clear),
    .en_i    (wr_sum_en),
    .word_i  (in_data),
    .sum_o   (wr_sum)
  );

`ifdef IMEM_LOADER_READBACK_EN
  logic        rd_vld_q;
  logic [31:0] rd_sum;

  // Read address goes out registered, cache answers one cycle later, so the
  // data for a read issued in VERIFY lands one cycle after that VERIFY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= (state_q == VERIFY);
    end
  end

  imem_rotxor_checksum u_rd_sum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (sum_clear),
    .en_i    (rd_vld_q),
    .word_i  (dbg_rdata),
    .sum_o   (rd_sum)
  );
`else
  logic unused_readback;
  assign unused_readback = ^{dbg_rdata, wr_sum};
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    error_d   = error_q;
    sum_clear = 1'b0;
    wr_sum_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = word_count;
          idx_d     = '0;
          error_d   = 1'b0;
          sum_clear = 1'b1;
          if (word_count == '0) begin
            state_d = DONE;
          end else if (word_count > MAX_N) begin
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (handshake) begin
          wr_en_d   = 1'b1;
          addr_d    = BASE_WORD + 30'(idx_q);
          wdata_d   = in_data;
          wr_sum_en = 1'b1;
          if (idx_q == n_q - ONE) begin
            state_d = WDRAIN;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end

      WDRAIN: begin
`ifdef IMEM_LOADER_READBACK_EN
        // Pre-issue word 0 so each VERIFY cycle has its own read on the bus.
        idx_d   = '0;
        addr_d  = BASE_WORD;
        state_d = VERIFY;
`else
        state_d = DONE;
`endif
      end

      VERIFY: begin
`ifdef IMEM_LOADER_READBACK_EN
        if (idx_q == n_q - ONE) begin
          state_d = RDRAIN;
        end else begin
          idx_d  = idx_q + ONE;
          addr_d = BASE_WORD + 30'(idx_q + ONE);
        end
`else
        state_d = DONE;
`endif
      end

      RDRAIN: begin
`ifdef IMEM_LOADER_READBACK_EN
        error_d = error_q | (rotl1_xor(rd_sum, dbg_rdata) != wr_sum);
`endif
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Hold stays up through the done pulse and drops the cycle after it.
    busy_d = (state_d != IDLE) | (state_q == DONE);
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign dbg_write_en = wr_en_q;
  assign dbg_addr     = addr_q;
  assign dbg_wdata    = wdata_q;
  assign cpu_hold     = busy_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: tb/tb_imem_debug_loader.sv
// Directed bench for imem_debug_loader: table of loads plus reset-abort and
// start-during-DONE sequences, with a small cache model on the debug port.
module tb_imem_debug_loader;

  localparam int          ADDR_W = 12;
  localparam logic [29:0] BASE   = 30'h100;
`ifdef IMEM_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [ADDR_W:0] word_count;
  logic            in_valid;
  logic [31:0]     in_data;
  logic            in_ready;
  logic            dbg_write_en;
  logic [29:0]     dbg_addr;
  logic [31:0]     dbg_wdata;
  logic [31:0]     dbg_rdata;
  logic            cpu_hold;
  logic            busy;
  logic            done;
  logic            error;

  int checks   = 0;
  int failures = 0;

  logic [61:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] mem[4096];
  bit          corrupt;

  typedef struct {
    logic [ADDR_W:0] n;
    bit              gap;
    logic [31:0]     mul;
    bit              corrupt;
    bit              exp_err;
    int              exp_writes;
    int              exp_done;
  } vec_t;

  imem_debug_loader #(.ADDR_W(ADDR_W), .BASE_WORD(BASE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .word_count   (word_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .dbg_write_en (dbg_write_en),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_rdata    (dbg_rdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // cache model: registered read, optional corruption of word 2
  always @(posedge clk) begin
    if (dbg_write_en)
      mem[dbg_addr[11:0]] <= (corrupt && dbg_addr == BASE + 30'd2) ? (dbg_wdata ^ 32'h0000_0100) : dbg_wdata;
    dbg_rdata <= mem[dbg_addr[11:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, dbg_write_en, 0);
    check({tag, "_addr"}, dbg_addr, 0);
    check({tag, "_wdata"}, dbg_wdata, 0);
    check({tag, "_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // one load: start pulse, stream driver, write scoreboard, done/error checks
  task automatic run_vec(input vec_t v);
    int          sent;
    int          writes;
    int          done_cyc;
    bit          fin;
    logic [61:0] e;
    int          ec;
    logic [31:0] w;
    sent = 0; writes = 0; done_cyc = -1; fin = 1'b0;
    corrupt = v.corrupt;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    start = 1'b1;
    word_count = v.n;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("hold_rise", cpu_hold, 1);
    for (int cyc = 1; cyc < 80 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (dbg_write_en) begin
        writes++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL write_unexpected actual=addr 0x%0h required=no write", dbg_addr);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("wr_addr", dbg_addr, e[61:32]);
          check("wr_data", dbg_wdata, e[31:0]);
          check("wr_latency", cyc, ec);
          check("wr_hold", cpu_hold, 1);
        end
      end
      if (done_cyc >= 0) begin
        check("done_once", done, 0);
        check("busy_fall", busy, 0);
        check("hold_fall", cpu_hold, 0);
        check("err_sticky", error, v.exp_err);
        fin = 1'b1;
      end else if (done) begin
        done_cyc = cyc;
        check("done_err", error, v.exp_err);
        check("done_cycle", done_cyc, v.exp_done);
        check("done_busy", busy, 1);
      end
      in_valid = 1'b0;
      if (!fin && sent < int'(v.n) && (!v.gap || (cyc % 2 == 1))) begin
        w        = v.mul * (sent + 1);
        in_valid = 1'b1;
        in_data  = w;
        if (in_ready) begin
          exp_q.push_back({BASE + 30'(sent), w});
          exp_cyc_q.push_back(cyc + 1);
          sent++;
        end
      end
    end
    in_valid = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no done required=done n=%0d", v.n);
    end
    check("write_count", writes, v.exp_writes);
    check("exp_left", exp_q.size(), 0);
  endtask

  vec_t vecs[6];

  initial begin
    // stimulus table
    vecs[0] = '{n: 13'd4,    gap: 0, mul: 32'h11,        corrupt: 0, exp_err: 0, exp_writes: 4, exp_done: RB ? 12 : 7};
    vecs[1] = '{n: 13'd4,    gap: 1, mul: 32'h11,        corrupt: 0, exp_err: 0, exp_writes: 4, exp_done: RB ? 15 : 10};
    vecs[2] = '{n: 13'd0,    gap: 0, mul: 32'h11,        corrupt: 0, exp_err: 0, exp_writes: 0, exp_done: 2};
    vecs[3] = '{n: 13'd4097, gap: 0, mul: 32'h11,        corrupt: 0, exp_err: 1, exp_writes: 0, exp_done: 2};
    vecs[4] = '{n: 13'd1,    gap: 0, mul: 32'hA5,        corrupt: 0, exp_err: 0, exp_writes: 1, exp_done: RB ? 6 : 4};
    vecs[5] = '{n: 13'd3,    gap: 1, mul: 32'h1000_0001, corrupt: 0, exp_err: 0, exp_writes: 3, exp_done: RB ? 12 : 8};

    rst_n = 1'b0; start = 1'b0; word_count = '0; in_valid = 1'b0; in_data = '0; corrupt = 1'b0;
    dbg_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifdef IMEM_LOADER_READBACK_EN
    run_vec('{n: 13'd4, gap: 0, mul: 32'h11, corrupt: 1, exp_err: 1, exp_writes: 4, exp_done: 12});
    run_vec('{n: 13'd4, gap: 0, mul: 32'h11, corrupt: 0, exp_err: 0, exp_writes: 4, exp_done: 12});
`endif

    // start during DONE is ignored
    @(negedge clk);
    start = 1'b1; word_count = 13'd0;
    @(negedge clk);
    word_count = 13'd1;
    @(negedge clk);
    start = 1'b0;
    check("ign_done", done, 1);
    @(negedge clk);
    check("ign_busy", busy, 0);
    for (int c = 0; c < 4; c++) begin
      check("ign_no_write", dbg_write_en, 0);
      check("ign_ready", in_ready, 0);
      @(negedge clk);
    end

    // reset in the middle of a load, then reload from BASE
    start = 1'b1; word_count = 13'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hDEAD_0000 + k;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("abort_wr_en", dbg_write_en, 1);
    check("abort_addr", dbg_addr, BASE + 30'd1);
    check("abort_ready", in_ready, 1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{n: 13'd2, gap: 0, mul: 32'h5A5A_0001, corrupt: 0, exp_err: 0, exp_writes: 2, exp_done: RB ? 8 : 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
